// File: rtl/jk_step_sequencer_pkg.sv
// Shared definitions for the JK step sequencer.
// Holds FSM encodings and JK excitation constants.
package jk_step_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // {J,K} per (q,nxt); don't-cares resolve to 0 so the cell holds
   localparam logic [1:0] EXC_00 = 2'b00;
   localparam logic [1:0] EXC_01 = 2'b10;
   localparam logic [1:0] EXC_10 = 2'b01;
   localparam logic [1:0] EXC_11 = 2'b00;

   function automatic logic [1:0] jk_exc(
      input logic q,
      input logic nxt
   );
      logic [1:0] r;
      unique case ({q, nxt})
         2'b00:   r = EXC_00;
         2'b01:   r = EXC_01;
         2'b10:   r = EXC_10;
         default: r = EXC_11;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_step_sequencer_cell.sv
// Single JK storage bit.
// Async active-high reset to 0.
module jk_cell_r (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= 1'b0;
      else       q <= (j & ~q) | (~k & q);
   end

endmodule

// File: rtl/jk_step_sequencer.sv
// Step sequencer walking a JK-cell register toward a target.
// Excitation is derived from the desired next state each cycle.
module jk_step_sequencer
   import jk_step_sequencer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             dir,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j_vec,
   output logic [WIDTH-1:0] k_vec,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [WIDTH-1:0] ONE = 1;

   state_t           state;
   state_t           state_nx;
   logic             dir_r;
   logic [WIDTH-1:0] target_r;
   logic             err_r;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] step;
   logic             req;
   logic             reject;
   logic             accept;

   assign step = dir_r ? q + ONE : q - ONE;

   // load has priority over start in IDLE
   assign req    = (state == ST_IDLE) && start && !load;
   assign reject = (WRAP == 1'b0) &&
                   ((dir && (target < q)) ||
                    (!dir && (target > q)));
   assign accept = req && !reject;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         dir_r    <= 1'b0;
         target_r <= '0;
         err_r    <= 1'b0;
      end else begin
         state <= state_nx;
         err_r <= req && reject;
         if (accept) begin
            dir_r    <= dir;
            target_r <= target;
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:
            if (accept)
               state_nx = (target == q) ? ST_DONE : ST_RUN;
         ST_RUN:
            if (step == target_r) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      nxt = q;
      unique case (state)
         ST_IDLE: if (load) nxt = load_val;
         ST_RUN:  nxt = step;
         default: nxt = q;
      endcase
   end

   always_comb begin
      j_vec = '0;
      k_vec = '0;
      for (int i = 0; i < WIDTH; i++)
         {j_vec[i], k_vec[i]} = jk_exc(q[i], nxt[i]);
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);
   assign err  = err_r;

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell_r u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j_vec[g]),
         .k     (k_vec[g]),
         .q     (q[g])
      );
   end

endmodule

// File: tb/tb_jk_step_sequencer.sv
// Directed bench for jk_step_sequencer.
// Runs a wrapping and a non-wrapping instance side by side.
module tb_jk_step_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [3:0] load_val;
   logic       start;
   logic       dir;
   logic [3:0] target;

   logic [3:0] q1, j1, k1;
   logic       busy1, done1, err1;
   logic [3:0] q0, j0, k0;
   logic       busy0, done0, err0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   jk_step_sequencer #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
      .clk(clk), .reset(reset), .load(load),
      .load_val(load_val), .start(start), .dir(dir),
      .target(target), .q(q1), .j_vec(j1), .k_vec(k1),
      .busy(busy1), .done(done1), .err(err1)
   );

   jk_step_sequencer #(.WIDTH(4), .WRAP(1'b0)) u_nowrap (
      .clk(clk), .reset(reset), .load(load),
      .load_val(load_val), .start(start), .dir(dir),
      .target(target), .q(q0), .j_vec(j0), .k_vec(k0),
      .busy(busy0), .done(done0), .err(err0)
   );

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_q(input logic [3:0] v);
      load     = 1'b1;
      load_val = v;
      tick();
      load     = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      load     = 1'b0;
      load_val = 4'h0;
      start    = 1'b0;
      dir      = 1'b1;
      target   = 4'h0;
      tick();
      tick();
      check("rst_q",    32'(q1),    0);
      check("rst_busy", 32'(busy1), 0);
      check("rst_done", 32'(done1), 0);
      check("rst_err",  32'(err1),  0);
      check("rst_j",    32'(j1),    0);
      check("rst_k",    32'(k1),    0);
      reset = 1'b0;
      tick();

      // load 9
      load     = 1'b1;
      load_val = 4'h9;
      #1;
      check("ld_j", 32'(j1), 32'h9);
      check("ld_k", 32'(k1), 32'h0);
      tick();
      load = 1'b0;
      #1;
      check("ld_q",    32'(q1), 32'h9);
      check("ld_idlej", 32'(j1), 32'h0);

      // walk 3 -> 7, with load/start noise mid-run
      load_q(4'h3);
      start  = 1'b1;
      dir    = 1'b1;
      target = 4'h7;
      tick();
      start = 1'b0;
      check("t3_j0", 32'(j1), 32'h4);
      check("t3_k0", 32'(k1), 32'h3);
      for (int i = 0; i < 4; i++) begin
         check("t3_busy", 32'(busy1), 1);
         check("t3_done", 32'(done1), 0);
         load     = (i == 1);
         load_val = 4'hA;
         start    = (i == 1);
         target   = (i == 1) ? 4'h0 : 4'h7;
         tick();
         check("t3_q", 32'(q1), 32'(4 + i));
      end
      load   = 1'b0;
      start  = 1'b0;
      check("t3_dn",   32'(done1), 1);
      check("t3_bz",   32'(busy1), 0);
      check("t3_err",  32'(err1),  0);
      tick();
      check("t3_dn1",  32'(done1), 0);
      check("t3_q1",   32'(q1),    32'h7);

      // wrap E -> F -> 0 -> 1
      load_q(4'hE);
      start  = 1'b1;
      dir    = 1'b1;
      target = 4'h1;
      tick();
      start = 1'b0;
      check("t4_busy", 32'(busy1), 1);
      check("t4_jE",   32'(j1),    32'h1);
      check("t4_kE",   32'(k1),    32'h0);
      check("t4_err0", 32'(err0),  1);
      check("t4_bz0",  32'(busy0), 0);
      tick();
      check("t4_qF", 32'(q1), 32'hF);
      check("t4_jF", 32'(j1), 32'h0);
      check("t4_kF", 32'(k1), 32'hF);
      tick();
      check("t4_q0", 32'(q1), 32'h0);
      tick();
      check("t4_q1", 32'(q1),    32'h1);
      check("t4_dn", 32'(done1), 1);
      tick();
      check("t4_dn1", 32'(done1), 0);

      // reject when target is behind and no wrap
      load_q(4'h8);
      start  = 1'b1;
      dir    = 1'b1;
      target = 4'h2;
      tick();
      start = 1'b0;
      check("t5_err",  32'(err0),  1);
      check("t5_q",    32'(q0),    32'h8);
      check("t5_bz",   32'(busy0), 0);
      check("t5_dn",   32'(done0), 0);
      tick();
      check("t5_err1", 32'(err0),  0);
      check("t5_q1",   32'(q0),    32'h8);
      for (int c = 0; c < 20 && !done1; c++) tick();
      check("t5_wdn", 32'(done1), 1);
      check("t5_wq",  32'(q1),    32'h2);
      tick();

      // start at target goes straight to DONE
      load_q(4'h6);
      start  = 1'b1;
      target = 4'h6;
      tick();
      start = 1'b0;
      check("t6_bz", 32'(busy1), 0);
      check("t6_dn", 32'(done1), 1);
      tick();
      check("t6_dn1", 32'(done1), 0);

      // load and start together: load only
      load     = 1'b1;
      load_val = 4'h2;
      start    = 1'b1;
      target   = 4'h5;
      tick();
      load  = 1'b0;
      start = 1'b0;
      check("t6_lq",  32'(q1),    32'h2);
      check("t6_lbz", 32'(busy1), 0);
      check("t6_ler", 32'(err1),  0);
      check("t6_ldn", 32'(done1), 0);
      tick();
      check("t6_lbz1", 32'(busy1), 0);

      // reset mid-run at q=5
      load_q(4'h0);
      start  = 1'b1;
      dir    = 1'b1;
      target = 4'h9;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("t1_q5",  32'(q1),    32'h5);
      check("t1_bz5", 32'(busy1), 1);
      #2;
      reset = 1'b1;
      #1;
      check("t1_q",  32'(q1),    0);
      check("t1_bz", 32'(busy1), 0);
      check("t1_dn", 32'(done1), 0);
      tick();
      reset = 1'b0;
      repeat (3) begin
         tick();
         check("t1_ndn", 32'(done1), 0);
         check("t1_nq",  32'(q1),    0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
